x_scope_dump: RTL and testbench
===============================

// Module: x_scope_dump
// PURPOSE
//  Autonomous readout controller for the micro-scope capture RAM. On one start pulse it reads
//  a contiguous window of capture words and streams each one, LSB byte first, to the UART TX.
//  The host no longer needs one deserialised command per byte. It sits between x_micro_scope's
//  read port and x_uart_tx, in place of the host-driven raddr/ren/mux path.
// PARAMETERS
//  ADDR_W   11  scope read address width; the window address wraps modulo 2**ADDR_W
//  DATA_W   32  scope word width; must be a multiple of 8; BYTES = DATA_W/8
// PORTS
//  i_clk        in   1         clock
//  i_rst        in   1         reset, asynchronous, active-high
//  i_start      in   1         start pulse; sampled only in IDLE
//  i_abort      in   1         abandon the dump; return to IDLE
//  i_base       in   ADDR_W    first word address; latched on accepted start
//  i_count      in   ADDR_W+1  number of words to send; 0 is legal; latched on accepted start
//  o_busy       out  1         high in every state except IDLE
//  o_done       out  1         one-cycle pulse when the window is complete (not raised on abort)
//  o_ren        out  1         scope read enable, one cycle per word
//  o_raddr      out  ADDR_W    scope read address
//  i_rdata      in   DATA_W    scope read data, valid the cycle after o_ren
//  o_tx_data    out  8         byte to UART TX
//  o_tx_valid   out  1         byte valid
//  i_tx_accept  in   1         UART TX takes the byte when it is high together with o_tx_valid
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0; addr, remaining, shift reg and byte_idx cleared.
//  FSM states: IDLE, RD, LAT, SEND, DONE. All outputs are registered or decoded from state.
//  IDLE: on i_start, latch addr=i_base and rem=i_count.
//    rem==0 -> DONE; else -> RD.
//  RD: o_ren=1, o_raddr=addr, for exactly one cycle -> LAT.
//  LAT: capture shreg<=i_rdata, byte_idx<=0 -> SEND.
//  SEND: o_tx_valid=1, o_tx_data=shreg[7:0]. Data stays stable until a transfer (valid&&accept).
//    On transfer with byte_idx<BYTES-1: shreg>>=8, byte_idx++, stay in SEND.
//    On transfer with byte_idx==BYTES-1: rem--.
//      rem was 1 -> DONE.
//      else addr<=addr+1 (wraps 2**ADDR_W-1 -> 0) -> RD.
//    After the last byte of a word, o_tx_valid drops for at least 2 cycles (RD, LAT).
//  DONE: o_done=1 for one cycle -> IDLE.
//  Latency: start accepted at cycle T gives o_ren at T+1, rdata captured at T+2, first
//    o_tx_valid at T+3. With accept held high, each word takes BYTES+2 cycles.
//  i_start while busy is ignored, with no queueing. i_base/i_count are don't-care outside the
//    accepted start cycle.
//  i_abort outside IDLE: next state is IDLE.
//    o_tx_valid, o_ren and o_busy drop next cycle. No o_done.
//    A byte transferred in the abort cycle counts as sent.
//    Abort in IDLE has no effect. Abort has priority over start in the same cycle.
//  i_start in the DONE cycle is ignored; the earliest restart is the IDLE cycle that follows.
//  i_count max = 2**ADDR_W gives a full RAM dump that ends at addr base-1 (mod 2**ADDR_W).
//  i_tx_accept while o_tx_valid=0 is ignored.
//  Async reset mid-dump returns to IDLE immediately. No o_done.
// TESTING
//  1. base=0, count=1, accept tied 1, RAM[0]=0xA1B2C3D4 -> bytes D4,C3,B2,A1;
//     o_ren at T+1, first valid at T+3, o_done at T+7.
//  2. base=2046, count=3 (ADDR_W=11) -> o_raddr 2046,2047,0 in order;
//     12 bytes total; single o_done.
//  3. count=0 -> no o_ren, no o_tx_valid; o_busy high 1 cycle and o_done pulse at T+1.
//  4. accept low for 5 cycles in mid-word -> o_tx_data and o_tx_valid held stable;
//     no byte lost or duplicated; extra start pulses mid-dump are ignored.
//  5. i_abort while sending byte 2 of word 1 of a count=4 dump -> IDLE next cycle, no o_done;
//     a new start then dumps cleanly from the new base.
//  6. i_rst asserted mid-SEND -> all outputs 0 immediately; after release, idle until i_start.

Source files
------------

// File: rtl/x_scope_dump_if.sv
// Signal bundle between the scope dump controller and its host, scope RAM read port and UART TX.
// Field names keep the original port names so existing hookups map one-to-one.
interface x_scope_dump_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              i_start;
  logic              i_abort;
  logic [ADDR_W-1:0] i_base;
  logic [ADDR_W:0]   i_count;
  logic              o_busy;
  logic              o_done;
  logic              o_ren;
  logic [ADDR_W-1:0] o_raddr;
  logic [DATA_W-1:0] i_rdata;
  logic [7:0]        o_tx_data;
  logic              o_tx_valid;
  logic              i_tx_accept;

  // The controller masters the read port and the TX byte stream.
  modport master (
    input  i_start, i_abort, i_base, i_count, i_rdata, i_tx_accept,
    output o_busy, o_done, o_ren, o_raddr, o_tx_data, o_tx_valid
  );

  modport slave (
    output i_start, i_abort, i_base, i_count, i_rdata, i_tx_accept,
    input  o_busy, o_done, o_ren, o_raddr, o_tx_data, o_tx_valid
  );
endinterface

// File: rtl/x_scope_dump.sv
// Autonomous capture-RAM readout: reads a window of scope words after one start pulse
// and streams each word LSB byte first to the UART TX.
module x_scope_dump #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input logic             i_clk,
  input logic             i_rst,
  x_scope_dump_if.master  bus
);

  localparam int BYTES  = DATA_W / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LAT,
    SEND,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   rem;
  logic [DATA_W-1:0] shreg;
  logic [BIDX_W-1:0] byte_idx;

  logic start_ok;
  logic xfer;
  logic last_byte;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start_ok  = 1'b0;
    xfer      = 1'b0;
    last_byte = 1'b0;
    case (state)
      IDLE: begin
        // Abort wins over a coincident start, so the start is dropped.
        if (bus.i_start && !bus.i_abort) begin
          start_ok = 1'b1;
          state_nx = (bus.i_count == '0) ? DONE : RD;
        end
      end
      RD:  state_nx = LAT;
      LAT: state_nx = SEND;
      SEND: begin
        xfer      = bus.i_tx_accept;
        last_byte = (byte_idx == LAST_IDX);
        if (xfer && last_byte)
          state_nx = (rem == (ADDR_W+1)'(1)) ? DONE : RD;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.i_abort && state != IDLE)
      state_nx = IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr     <= '0;
      rem      <= '0;
      shreg    <= '0;
      byte_idx <= '0;
    end else begin
      if (start_ok) begin
        addr <= bus.i_base;
        rem  <= bus.i_count;
      end
      if (state == LAT) begin
        shreg    <= bus.i_rdata;
        byte_idx <= '0;
      end
      if (xfer) begin
        if (!last_byte) begin
          shreg    <= shreg >> 8;
          byte_idx <= byte_idx + BIDX_W'(1);
        end else begin
          rem <= rem - (ADDR_W+1)'(1);
          // Address advances only when another word follows; wraps naturally at ADDR_W bits.
          if (rem != (ADDR_W+1)'(1))
            addr <= addr + ADDR_W'(1);
        end
      end
    end
  end

  assign bus.o_busy     = (state != IDLE);
  assign bus.o_done     = (state == DONE);
  assign bus.o_ren      = (state == RD);
  assign bus.o_raddr    = addr;
  assign bus.o_tx_valid = (state == SEND);
  assign bus.o_tx_data  = shreg[7:0];

endmodule

// File: tb/tb_x_scope_dump.sv
// Bench for x_scope_dump: scope RAM model, output monitor and a window-level reference model.
module tb_x_scope_dump;

  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int DEPTH = 2048;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [0:DEPTH-1];

  logic [7:0] obs_bytes [$];
  int         obs_addr  [$];
  int         ren_cyc   [$];
  int         done_cyc  [$];
  int         first_valid;
  int         busy_cnt;

  logic [7:0] exp_bytes [$];
  int         exp_addr  [$];

  x_scope_dump_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  x_scope_dump #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scope RAM: data appears the cycle after the read enable.
  always @(posedge clk) if (bus.o_ren) bus.i_rdata <= mem[bus.o_raddr];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_ren) begin
        obs_addr.push_back(int'(bus.o_raddr));
        ren_cyc.push_back(cyc);
      end
      if (bus.o_tx_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (bus.i_tx_accept) obs_bytes.push_back(bus.o_tx_data);
      end
      if (bus.o_done) done_cyc.push_back(cyc);
      if (bus.o_busy) busy_cnt++;
    end
  end

  task automatic clear_obs();
    obs_bytes.delete();
    obs_addr.delete();
    ren_cyc.delete();
    done_cyc.delete();
    first_valid = -1;
    busy_cnt    = 0;
  endtask

  // Expected stream of a window: consecutive words (address mod depth), LSB byte first.
  task automatic build_exp(input int base, input int count);
    exp_bytes.delete();
    exp_addr.delete();
    for (int w = 0; w < count; w++) begin
      int a;
      logic [DW-1:0] word;
      a = (base + w) % DEPTH;
      word = mem[a];
      exp_addr.push_back(a);
      for (int k = 0; k < DW/8; k++) exp_bytes.push_back(8'((word >> (8*k)) & 32'hFF));
    end
  endtask

  task automatic start_dump(input int base, input int count, output int t0);
    @(posedge clk); #1;
    clear_obs();
    bus.i_start = 1'b1;
    bus.i_base  = AW'(base);
    bus.i_count = (AW+1)'(count);
    t0 = cyc;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  task automatic wait_idle(input int max, input bit rand_acc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!bus.o_busy) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      if (rand_acc) bus.i_tx_accept = 1'($urandom_range(0, 1));
    end
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", bus.o_busy, max);
    end
    bus.i_tx_accept = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_tx_accept = 1'b0;
    bus.i_base = '0; bus.i_count = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    n_checks++; if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
    n_checks++; if (bus.o_ren !== 1'b0) begin n_fail++; $display("FAIL reset_ren: got %b want 0", bus.o_ren); end
    n_checks++; if (bus.o_raddr !== '0) begin n_fail++; $display("FAIL reset_raddr: got %0d want 0", bus.o_raddr); end
    n_checks++; if (bus.o_tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.o_tx_valid); end
    n_checks++; if (bus.o_tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus.o_tx_data); end
    @(negedge clk); rst = 1'b0;
    clear_obs();
  endtask

  task automatic test_single_word();
    int t0;
    logic [7:0] want [4];
    want[0] = 8'hD4; want[1] = 8'hC3; want[2] = 8'hB2; want[3] = 8'hA1;
    mem[0] = 32'hA1B2C3D4;
    bus.i_tx_accept = 1'b1;
    start_dump(0, 1, t0);
    wait_idle(50, 1'b0);
    n_checks++;
    if (obs_bytes.size() != 4) begin n_fail++; $display("FAIL single_nbytes: got %0d want 4", obs_bytes.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_bytes[i] !== want[i]) begin n_fail++; $display("FAIL single_byte%0d: got %h want %h", i, obs_bytes[i], want[i]); end
    end
    n_checks++; if (ren_cyc.size() != 1 || ren_cyc[0] != t0 + 1) begin n_fail++; $display("FAIL single_ren_time: got n=%0d c=%0d want c=%0d", ren_cyc.size(), (ren_cyc.size() > 0) ? ren_cyc[0] - t0 : -1, 1); end
    n_checks++; if (first_valid != t0 + 3) begin n_fail++; $display("FAIL single_valid_time: got %0d want %0d", first_valid - t0, 3); end
    n_checks++; if (done_cyc.size() != 1 || done_cyc[0] != t0 + 7) begin n_fail++; $display("FAIL single_done_time: got n=%0d c=%0d want c=7", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] - t0 : -1); end
  endtask

  task automatic test_wrap();
    int t0;
    int want_addr [3];
    want_addr[0] = 2046; want_addr[1] = 2047; want_addr[2] = 0;
    build_exp(2046, 3);
    start_dump(2046, 3, t0);
    wait_idle(200, 1'b1);
    n_checks++;
    if (obs_addr.size() != 3) begin n_fail++; $display("FAIL wrap_naddr: got %0d want 3", obs_addr.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_addr[i] != want_addr[i]) begin n_fail++; $display("FAIL wrap_addr%0d: got %0d want %0d", i, obs_addr[i], want_addr[i]); end
    end
    n_checks++;
    if (obs_bytes.size() != 12) begin n_fail++; $display("FAIL wrap_nbytes: got %0d want 12", obs_bytes.size()); end
    else for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (obs_bytes[i] !== exp_bytes[i]) begin n_fail++; $display("FAIL wrap_byte%0d: got %h want %h", i, obs_bytes[i], exp_bytes[i]); end
    end
    n_checks++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL wrap_done_count: got %0d want 1", done_cyc.size()); end
  endtask

  task automatic test_zero_count();
    int t0;
    start_dump(int'($urandom_range(0, DEPTH-1)), 0, t0);
    wait_idle(20, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++; if (ren_cyc.size() != 0) begin n_fail++; $display("FAIL zero_ren: got %0d reads want 0", ren_cyc.size()); end
    n_checks++; if (first_valid >= 0) begin n_fail++; $display("FAIL zero_valid: got valid at %0d want none", first_valid - t0); end
    n_checks++; if (busy_cnt != 1) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d want 1", busy_cnt); end
    n_checks++; if (done_cyc.size() != 1 || done_cyc[0] != t0 + 1) begin n_fail++; $display("FAIL zero_done: got n=%0d c=%0d want c=1", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] - t0 : -1); end
  endtask

  task automatic test_stall();
    int t0, base;
    base = int'($urandom_range(0, DEPTH-1));
    build_exp(base, 3);
    bus.i_tx_accept = 1'b1;
    start_dump(base, 3, t0);
    repeat (3) @(posedge clk);
    #1;
    bus.i_tx_accept = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.o_tx_valid !== 1'b1 || bus.o_tx_data !== exp_bytes[1]) begin
        n_fail++; $display("FAIL stall_hold%0d: got v=%b d=%h want v=1 d=%h", i, bus.o_tx_valid, bus.o_tx_data, exp_bytes[1]);
      end
      @(posedge clk); #1;
      bus.i_start = (i == 2 || i == 3);
      bus.i_base  = AW'(base + 100);
      bus.i_count = (AW+1)'(7);
    end
    bus.i_start = 1'b0;
    bus.i_tx_accept = 1'b1;
    wait_idle(200, 1'b0);
    repeat (5) @(negedge clk);
    n_checks++;
    if (obs_bytes.size() != exp_bytes.size()) begin n_fail++; $display("FAIL stall_nbytes: got %0d want %0d", obs_bytes.size(), exp_bytes.size()); end
    else foreach (exp_bytes[i]) begin
      n_checks++;
      if (obs_bytes[i] !== exp_bytes[i]) begin n_fail++; $display("FAIL stall_byte%0d: got %h want %h", i, obs_bytes[i], exp_bytes[i]); end
    end
    n_checks++; if (obs_addr != exp_addr) begin n_fail++; $display("FAIL stall_addrs: got %0d reads want %0d", obs_addr.size(), exp_addr.size()); end
    n_checks++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL stall_done_count: got %0d want 1", done_cyc.size()); end
  endtask

  task automatic test_abort();
    int t0, base, base2;
    base = int'($urandom_range(0, DEPTH-1));
    build_exp(base, 4);
    bus.i_tx_accept = 1'b1;
    start_dump(base, 4, t0);
    repeat (10) @(posedge clk);
    #1;
    bus.i_abort = 1'b1;
    @(posedge clk); #1;
    bus.i_abort = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.o_busy !== 1'b0 || bus.o_tx_valid !== 1'b0 || bus.o_ren !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got busy=%b valid=%b ren=%b want 0 0 0", bus.o_busy, bus.o_tx_valid, bus.o_ren);
    end
    repeat (5) @(negedge clk);
    n_checks++; if (done_cyc.size() != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d done pulses want 0", done_cyc.size()); end
    n_checks++;
    if (obs_bytes.size() != 7) begin n_fail++; $display("FAIL abort_nbytes: got %0d want 7", obs_bytes.size()); end
    else for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (obs_bytes[i] !== exp_bytes[i]) begin n_fail++; $display("FAIL abort_byte%0d: got %h want %h", i, obs_bytes[i], exp_bytes[i]); end
    end
    base2 = (base + 500) % DEPTH;
    build_exp(base2, 2);
    start_dump(base2, 2, t0);
    wait_idle(200, 1'b1);
    n_checks++; if (obs_bytes != exp_bytes) begin n_fail++; $display("FAIL abort_restart_bytes: got %0d bytes want %0d", obs_bytes.size(), exp_bytes.size()); end
    n_checks++; if (obs_addr != exp_addr) begin n_fail++; $display("FAIL abort_restart_addrs: got first %0d want %0d", (obs_addr.size() > 0) ? obs_addr[0] : -1, base2); end
    n_checks++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL abort_restart_done: got %0d want 1", done_cyc.size()); end
  endtask

  task automatic test_reset_mid();
    int t0;
    bus.i_tx_accept = 1'b1;
    start_dump(int'($urandom_range(0, DEPTH-1)), 2, t0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.o_busy, bus.o_done, bus.o_ren, bus.o_tx_valid} !== 4'b0 || bus.o_tx_data !== 8'h00 || bus.o_raddr !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got busy=%b done=%b ren=%b valid=%b data=%h raddr=%0d want all 0",
        bus.o_busy, bus.o_done, bus.o_ren, bus.o_tx_valid, bus.o_tx_data, bus.o_raddr);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_obs();
    repeat (8) @(negedge clk);
    n_checks++; if (busy_cnt != 0 || ren_cyc.size() != 0 || done_cyc.size() != 0) begin
      n_fail++; $display("FAIL rstmid_idle: got busy=%0d reads=%0d dones=%0d want 0 0 0", busy_cnt, ren_cyc.size(), done_cyc.size());
    end
  endtask

  task automatic test_back_to_back();
    int t0, b1, b2;
    b1 = int'($urandom_range(0, DEPTH-1));
    b2 = (b1 + 37) % DEPTH;
    bus.i_tx_accept = 1'b1;
    @(posedge clk); #1;
    clear_obs();
    bus.i_start = 1'b1; bus.i_base = AW'(b1); bus.i_count = (AW+1)'(1);
    t0 = cyc;
    @(posedge clk); #1;
    bus.i_base = AW'(b2);
    repeat (8) @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    wait_idle(50, 1'b0);
    n_checks++; if (ren_cyc.size() != 2 || ren_cyc[0] != t0 + 1 || ren_cyc[1] != t0 + 9) begin
      n_fail++; $display("FAIL b2b_ren_times: got n=%0d second=%0d want 2 reads at 1 and 9", ren_cyc.size(), (ren_cyc.size() > 1) ? ren_cyc[1] - t0 : -1);
    end
    n_checks++; if (done_cyc.size() != 2 || done_cyc[1] != t0 + 15) begin
      n_fail++; $display("FAIL b2b_done: got n=%0d second=%0d want 2 with second at 15", done_cyc.size(), (done_cyc.size() > 1) ? done_cyc[1] - t0 : -1);
    end
    n_checks++; if (obs_addr.size() != 2 || obs_addr[0] != b1 || obs_addr[1] != b2) begin
      n_fail++; $display("FAIL b2b_addrs: got n=%0d want %0d then %0d", obs_addr.size(), b1, b2);
    end
  endtask

  task automatic test_random();
    int t0, base, count;
    for (int r = 0; r < 5; r++) begin
      base  = int'($urandom_range(0, DEPTH-1));
      count = int'($urandom_range(1, 20));
      build_exp(base, count);
      start_dump(base, count, t0);
      wait_idle(2000, 1'b1);
      n_checks++; if (obs_bytes != exp_bytes) begin n_fail++; $display("FAIL rand%0d_bytes: got %0d bytes want %0d (base %0d)", r, obs_bytes.size(), exp_bytes.size(), base); end
      n_checks++; if (obs_addr != exp_addr) begin n_fail++; $display("FAIL rand%0d_addrs: got %0d reads want %0d", r, obs_addr.size(), exp_addr.size()); end
      n_checks++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL rand%0d_done: got %0d want 1", r, done_cyc.size()); end
    end
  endtask

  task automatic test_full_dump();
    int t0, base;
    base = int'($urandom_range(0, DEPTH-1));
    build_exp(base, DEPTH);
    bus.i_tx_accept = 1'b1;
    start_dump(base, DEPTH, t0);
    wait_idle(20000, 1'b0);
    n_checks++; if (obs_addr.size() != DEPTH || obs_addr[DEPTH-1] != (base + DEPTH - 1) % DEPTH) begin
      n_fail++; $display("FAIL full_last_addr: got n=%0d last=%0d want %0d", obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[obs_addr.size()-1] : -1, (base + DEPTH - 1) % DEPTH);
    end
    n_checks++; if (obs_bytes != exp_bytes) begin n_fail++; $display("FAIL full_bytes: got %0d bytes want %0d", obs_bytes.size(), exp_bytes.size()); end
    n_checks++; if (done_cyc.size() != 1 || done_cyc[0] != t0 + 1 + 6*DEPTH) begin
      n_fail++; $display("FAIL full_done_time: got n=%0d c=%0d want c=%0d", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] - t0 : -1, 1 + 6*DEPTH);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    test_reset();
    test_single_word();
    test_wrap();
    test_zero_count();
    test_stall();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_full_dump();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
